uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, frame width and the
// default clocks-per-bit constant used by both uart_tx and uart_rx.
package uart_pkg;

  // 16 MHz / 1666 clocks per bit is roughly 9600 baud.
  localparam int unsigned BAUD_MULT_DEFAULT = 1666;

  // 8N1 framing: eight data bits, LSB first.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset value so an idle-high line does not look like activity.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises the serial line, finds the start bit,
// samples every bit at its midpoint with a down-counter, and reports the
// received byte (or a framing error) with single-cycle strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_MULT = BAUD_MULT_DEFAULT
) (
  input  logic       i_uart_clk,
  input  logic       i_uart_rst_n,
  input  logic       i_rx_data,
  output logic [7:0] o_byte,
  output logic       o_data_valid,
  output logic       o_rx_active,
  output logic       o_framing_error
);

  localparam int unsigned CNT_W = $clog2(BAUD_MULT);
  // Reload values: first wait lands on the start-bit midpoint, later waits
  // step a whole bit period from one midpoint to the next.
  localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(BAUD_MULT / 2 - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(BAUD_MULT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 sample_pt;

  rx_state_e            state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] byte_q,    byte_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_uart_clk),
    .rst_n (i_uart_rst_n),
    .d     (i_rx_data),
    .q     (rx_s)
  );

  assign sample_pt = (cnt_q == '0);

  // Register FSM state, bit timing and output strobes.
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state, bit-period counter, shift register and strobe generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end

      START: begin
        if (sample_pt) begin
          if (rx_s) begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
            cnt_d     = CNT_FULL;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DATA: begin
        if (sample_pt) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      STOP: begin
        if (sample_pt) begin
          // Leave at the stop midpoint so a start bit right after a
          // one-bit stop is still caught.
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        // Hold off until a break ends so it yields only one error pulse.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_byte          = byte_q;
  assign o_data_valid    = valid_q;
  assign o_framing_error = ferr_q;
  assign o_rx_active     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with BAUD_MULT = 8: table of frames, hand-written
// corner sequences and random frames, all checked against an event model
// that predicts when each valid/error strobe appears and what byte it shows.
module tb_uart_rx;

  localparam int unsigned M = 8;
  // Pin edge to strobe: 2 sync cycles + half bit + 9 bits + 1 register.
  localparam int LAT = 2 + M / 2 + 9 * M + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_byte;
  logic       o_valid;
  logic       o_active;
  logic       o_ferr;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         is_err;
    int         cycle;
    logic [7:0] data;
    bit         both;
  } event_t;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         gap;
    bit         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  event_t     got_q[$];
  event_t     exp_q[$];
  int         got_rd = 0;
  logic [7:0] last_good = 8'h00;
  vec_t       vecs[19];

  uart_rx #(
    .BAUD_MULT (M)
  ) dut (
    .i_uart_clk      (clk),
    .i_uart_rst_n    (rst_n),
    .i_rx_data       (rx),
    .o_byte          (o_byte),
    .o_data_valid    (o_valid),
    .o_rx_active     (o_active),
    .o_framing_error (o_ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe with the cycle it was seen in and the byte shown.
  always @(negedge clk) begin
    if (rst_n && (o_valid || o_ferr)) begin
      got_q.push_back('{o_ferr && !o_valid, cyc, o_byte, o_valid && o_ferr});
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, required, required);
    end
  endtask

  task automatic drive_bits(input logic [7:0] b);
    rx = 1'b0;
    tick(M);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(M);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input int gap, output int p);
    p = cyc;
    drive_bits(b);
    if (stop_low > 0) begin
      rx = 1'b0;
      tick(stop_low);
    end
    rx = 1'b1;
    tick(M);
    tick(gap);
  endtask

  // Model: a good frame shows its byte; a bad stop shows the last good byte.
  task automatic model_frame(input int p, input logic [7:0] b, input bit is_err);
    if (!is_err) last_good = b;
    exp_q.push_back('{is_err, p + LAT, last_good, 1'b0});
  endtask

  task automatic check_events(input string name);
    int n_got;
    int n;
    event_t g;
    event_t e;
    tick(M);
    n_got = got_q.size() - got_rd;
    check({name, "_count"}, n_got, exp_q.size());
    n = (n_got < exp_q.size()) ? n_got : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q[got_rd + i];
      e = exp_q[i];
      vectors++;
      if (g.is_err != e.is_err || g.cycle != e.cycle || g.data !== e.data || g.both) begin
        miscompares++;
        $display("FAIL %s[%0d]: got err=%0b cycle=%0d byte=0x%02h both=%0b, expected err=%0b cycle=%0d byte=0x%02h both=0",
                 name, i, g.is_err, g.cycle, g.data, g.both, e.is_err, e.cycle, e.data);
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int         p;
    string      s;
    logic [7:0] b;
    bit         err;
    int         sl;
    int         gap;

    // Reset state
    rx    = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("rst_byte", int'(o_byte), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_active", int'(o_active), 0);
    check("rst_ferr", int'(o_ferr), 0);
    rst_n = 1'b1;
    tick(5);
    check("post_rst_active", int'(o_active), 0);

    // Table: "Hello World!\n" back-to-back, loopback bytes, a break, recovery
    s = "Hello World!\n";
    for (int i = 0; i < 13; i++) vecs[i] = '{s[i], 0, 0, 1'b0, s[i]};
    vecs[13] = '{8'h00, 0, 0, 1'b0, 8'h00};
    vecs[14] = '{8'hFF, 0, 0, 1'b0, 8'hFF};
    vecs[15] = '{8'h01, 0, 0, 1'b0, 8'h01};
    vecs[16] = '{8'h80, 0, 0, 1'b0, 8'h80};
    vecs[17] = '{8'hA5, 20, 3, 1'b1, 8'h80};
    vecs[18] = '{8'h3C, 0, 2, 1'b0, 8'h3C};
    for (int i = 0; i < 19; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_low, vecs[i].gap, p);
      exp_q.push_back('{vecs[i].exp_err, p + LAT, vecs[i].exp_byte, 1'b0});
      if (!vecs[i].exp_err) last_good = vecs[i].exp_byte;
    end
    check_events("table");
    check("table_last_byte", int'(o_byte), 'h3C);

    // Single isolated 'H'
    tick(5);
    send_frame(8'h48, 0, 0, p);
    model_frame(p, 8'h48, 1'b0);
    check_events("single_H");
    check("single_H_byte", int'(o_byte), 'h48);

    // 3-cycle low glitch, then 0x55
    p  = cyc;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(1);
    check("glitch_active_hi", int'(o_active), 1);
    tick(6);
    check("glitch_active_lo", int'(o_active), 0);
    tick(8);
    send_frame(8'h55, 0, 0, p);
    model_frame(p, 8'h55, 1'b0);
    check_events("glitch");

    // 0xA5 with stop held low 30 cycles, then 0x3C
    p = cyc;
    drive_bits(8'hA5);
    rx = 1'b0;
    tick(26);
    check("break_active_low_line", int'(o_active), 1);
    tick(4);
    rx = 1'b1;
    tick(6);
    check("break_active_after", int'(o_active), 0);
    check("break_byte_held", int'(o_byte), 'h55);
    model_frame(p, 8'hA5, 1'b1);
    tick(2);
    send_frame(8'h3C, 0, 0, p);
    model_frame(p, 8'h3C, 1'b0);
    check_events("break");

    // Reset during data bit 4 of 0xFF, then 0x81
    p  = cyc;
    rx = 1'b0;
    tick(M);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(M);
    end
    tick(4);
    check("midrst_active_before", int'(o_active), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_active", int'(o_active), 0);
    check("midrst_byte", int'(o_byte), 0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_ferr", int'(o_ferr), 0);
    tick(2);
    rst_n = 1'b1;
    last_good = 8'h00;
    tick(2 * M);
    send_frame(8'h81, 0, 0, p);
    model_frame(p, 8'h81, 1'b0);
    check_events("reset_abort");
    check("reset_abort_byte", int'(o_byte), 'h81);

    // Random frames with random gaps and occasional broken stop bits
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 5) == 0);
      sl  = err ? int'($urandom_range(5, 24)) : 0;
      gap = int'($urandom_range(0, 6));
      send_frame(b, sl, gap, p);
      model_frame(p, b, err);
    end
    check_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
